data_ram_loader: RTL

Write-side initiator for the DataRAM. It accepts a byte stream over a valid/ready handshake and issues sequential write cycles on the DataRAM port (MemWrite, Address, DataSrc), starting at a programmable base address. This makes DataRAM contents loadable in hardware, for example from a host link or a boot sequencer. An optional readback pass reads the written window back through MemRead/DataMemOut and flags checksum mismatches.

---
 rtl/data_ram_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/data_ram_loader.sv
// DataRAM write-side loader: streams bytes from a valid/ready source into sequential DataRAM writes from a base address.
// Latency: one registered write stage; Done two cycles after the last accepted byte (plus Count read cycles when LOADER_VERIFY_EN is defined).
// Backpressure: InReady is high only while bytes remain in LOAD; the optional LOADER_VERIFY_EN readback flags checksum mismatches on Error.
module data_ram_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W:0]   Count,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataSrc,
  input  logic [DATA_W-1:0] DataMemOut,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    VERIFY,
    DONE
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W:0]    remaining;
  logic [DATA_W-1:0]  checksum;
  logic               memWriteQ;
  logic [ADDR_W-1:0]  addrQ;
  logic [DATA_W-1:0]  dataQ;
  logic               accept;

`ifdef LOADER_VERIFY_EN
  logic [ADDR_W-1:0]  baseQ;
  logic [ADDR_W:0]    countQ;
  logic [DATA_W-1:0]  readSum;
  logic               errorQ;
`else
  // Read data only matters for the readback pass.
  logic               unusedDataMemOut;
  assign unusedDataMemOut = ^DataMemOut;
`endif

  assign InReady  = (state == LOAD) && (remaining != '0);
  assign accept   = InValid && InReady;
  assign MemWrite = memWriteQ;
  // Address is a single register shared by write and read phases so it holds its last value when idle.
  assign Address  = addrQ;
  assign DataSrc  = dataQ;
  assign Busy     = (state == LOAD) || (state == FLUSH) || (state == VERIFY);
  assign Done     = (state == DONE);
`ifdef LOADER_VERIFY_EN
  assign MemRead  = (state == VERIFY);
  assign Error    = errorQ;
`else
  assign MemRead  = 1'b0;
  assign Error    = 1'b0;
`endif

  // Next-state logic; LOAD waits one cycle at remaining==0 so the last registered write can commit.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (Start) stateNext = (Count == '0) ? DONE : LOAD;
      LOAD:   if (remaining == '0) stateNext = FLUSH;
`ifdef LOADER_VERIFY_EN
      FLUSH:  stateNext = VERIFY;
      VERIFY: if (remaining == 1) stateNext = DONE;
`else
      FLUSH:  stateNext = DONE;
`endif
      DONE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register, write stage, pointers, checksum and readback comparison.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      checksum  <= '0;
      memWriteQ <= 1'b0;
      addrQ     <= '0;
      dataQ     <= '0;
`ifdef LOADER_VERIFY_EN
      baseQ     <= '0;
      countQ    <= '0;
      readSum   <= '0;
      errorQ    <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      memWriteQ <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            ptr       <= BaseAddr;
            remaining <= Count;
            checksum  <= '0;
`ifdef LOADER_VERIFY_EN
            baseQ     <= BaseAddr;
            countQ    <= Count;
            readSum   <= '0;
            errorQ    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            memWriteQ <= 1'b1;
            addrQ     <= ptr;
            dataQ     <= InData;
            ptr       <= ptr + 1'b1;
            checksum  <= checksum + InData;
            remaining <= remaining - 1'b1;
          end
        end
`ifdef LOADER_VERIFY_EN
        FLUSH: begin
          ptr       <= baseQ;
          addrQ     <= baseQ;
          remaining <= countQ;
        end
        VERIFY: begin
          readSum   <= readSum + DataMemOut;
          remaining <= remaining - 1'b1;
          ptr       <= ptr + 1'b1;
          // Last read keeps Address parked on the final window location.
          if (remaining == 1) begin
            errorQ <= ((readSum + DataMemOut) != checksum);
          end else begin
            addrQ  <= addrQ + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
